// File: rtl/led_pattern_gen_if.sv
// Configuration write port and LED outputs for led_pattern_gen.
// The master drives the cfg_* strobe; the slave (the generator) drives led/evt.
interface led_pattern_gen_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 15,
  parameter int CH_W     = 2
);
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_mode;
  logic [CNT_W-1:0]    cfg_half;
  logic [3:0]          cfg_burst;
  logic [CHANNELS-1:0] led;
  logic [CHANNELS-1:0] evt;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_burst,
    input  led, evt
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_burst,
    output led, evt
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel half-period counter driving
// OFF / ON / BLINK / BURST patterns, retunable at run time through io_bus.
module led_pattern_gen #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 15,
  parameter int DEFAULT_HALF = 25000,
  parameter int CH_W         = 2
) (
  input logic             i_clk,
  input logic             i_reset,
  led_pattern_gen_if.slave io_bus
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] LP_RST_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] LP_RST_CNT  = CNT_W'(DEFAULT_HALF - 1);

  mode_t               r_mode  [CHANNELS];
  logic [CNT_W-1:0]    r_half  [CHANNELS];
  logic [3:0]          r_burst [CHANNELS];
  logic [CNT_W-1:0]    r_cnt   [CHANNELS];
  logic [5:0]          r_ph    [CHANNELS];
  logic [CHANNELS-1:0] r_led;
  logic [CHANNELS-1:0] r_evt;

  mode_t               w_mode   [CHANNELS];
  logic [CNT_W-1:0]    w_half   [CHANNELS];
  logic [3:0]          w_burst  [CHANNELS];
  logic [CNT_W-1:0]    w_cnt    [CHANNELS];
  logic [5:0]          w_ph     [CHANNELS];
  logic [5:0]          w_phLast [CHANNELS];
  logic [5:0]          w_phStep [CHANNELS];
  logic [CHANNELS-1:0] w_led;
  logic [CHANNELS-1:0] w_evt;

  logic                w_wrValid;
  logic [CH_W-1:0]     w_cfgCh;
  mode_t               w_cfgMode;
  logic [CNT_W-1:0]    w_cfgHalf;
  logic [3:0]          w_cfgBurst;

  // Zero half-period and zero burst count are stored as 1 so the counters never see 0.
  assign w_cfgCh    = io_bus.cfg_ch;
  assign w_wrValid  = io_bus.cfg_we && (int'(w_cfgCh) < CHANNELS);
  assign w_cfgMode  = mode_t'(io_bus.cfg_mode);
  assign w_cfgHalf  = (io_bus.cfg_half == '0) ? CNT_W'(1) : io_bus.cfg_half;
  assign w_cfgBurst = (io_bus.cfg_burst == 4'd0) ? 4'd1 : io_bus.cfg_burst;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_mode[i]   = r_mode[i];
      w_half[i]   = r_half[i];
      w_burst[i]  = r_burst[i];
      w_cnt[i]    = r_cnt[i];
      w_ph[i]     = r_ph[i];
      w_led[i]    = r_led[i];
      w_evt[i]    = 1'b0;
      w_phLast[i] = {r_burst[i], 2'b00} - 6'd1;
      w_phStep[i] = (r_ph[i] == w_phLast[i]) ? 6'd0 : r_ph[i] + 6'd1;

      // A write to this channel restarts it and suppresses any coincident terminal count.
      if (w_wrValid && (int'(w_cfgCh) == i)) begin
        w_mode[i]  = w_cfgMode;
        w_half[i]  = w_cfgHalf;
        w_burst[i] = w_cfgBurst;
        w_cnt[i]   = w_cfgHalf - CNT_W'(1);
        w_ph[i]    = 6'd0;
        w_led[i]   = (w_cfgMode == MODE_ON) || (w_cfgMode == MODE_BURST);
      end else if (r_cnt[i] == '0) begin
        w_cnt[i] = r_half[i] - CNT_W'(1);
        w_evt[i] = 1'b1;
        case (r_mode[i])
          MODE_OFF:   w_led[i] = 1'b0;
          MODE_ON:    w_led[i] = 1'b1;
          MODE_BLINK: w_led[i] = ~r_led[i];
          MODE_BURST: begin
            w_ph[i]  = w_phStep[i];
            w_led[i] = (w_phStep[i] < {1'b0, r_burst[i], 1'b0}) && !w_phStep[i][0];
          end
          default:    w_led[i] = r_led[i];
        endcase
      end else begin
        w_cnt[i] = r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_mode[i]  <= MODE_BLINK;
        r_half[i]  <= LP_RST_HALF;
        r_burst[i] <= 4'd1;
        r_cnt[i]   <= LP_RST_CNT;
        r_ph[i]    <= 6'd0;
      end
      r_led <= '0;
      r_evt <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_mode[i]  <= w_mode[i];
        r_half[i]  <= w_half[i];
        r_burst[i] <= w_burst[i];
        r_cnt[i]   <= w_cnt[i];
        r_ph[i]    <= w_ph[i];
      end
      r_led <= w_led;
      r_evt <= w_evt;
    end
  end

  assign io_bus.led = r_led;
  assign io_bus.evt = r_evt;

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel, run-time configurable LED pattern generator: the parametrised successor to the team's fixed single-LED divide-by-25000 blinker. Each channel has its own half-period counter and one of four modes: off, on, continuous blink, or burst (B blinks, then an equal dark gap). It sits between the board clock and the LED pins. A simple write port lets firmware or a test harness retune channels without reset.

## Interface
Parameters:
- CHANNELS, 4, number of independent LED channels (1..16)
- CNT_W, 15, width of half-period counter and cfg_half
- DEFAULT_HALF, 25000, reset half-period in cycles (must fit CNT_W, ≥1)
- CH_W, 2, width of cfg_ch (≥ ceil(log2(CHANNELS)), min 1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- cfg_we  in  1  write strobe, one-cycle, applies cfg_* to channel cfg_ch
- cfg_ch  in  CH_W  target channel index
- cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 BURST
- cfg_half  in  CNT_W  half-period in cycles; 0 treated as 1
- cfg_burst  in  4  blinks per burst; 0 treated as 1
- led  out  CHANNELS  registered LED outputs
- evt  out  CHANNELS  registered one-cycle pulse per channel terminal count

## Operation
- Per channel state: mode, half (H), burst (B), counter cnt, phase index ph (0..4B-1), led bit.
- Reset (reset=1 at an edge, regardless of cfg_we): all channels mode=BLINK, H=DEFAULT_HALF, B=1, cnt=DEFAULT_HALF-1, ph=0, led=0, evt=0. Reset mid-pattern discards all state.
- Counter, all modes: if cnt==0 then cnt<=H-1 and a terminal event (TC) occurs; else cnt<=cnt-1. H=0 behaves as H=1 (TC every cycle).
- evt[i] <= TC of channel i; asserted in the same cycle that led reflects the TC action.
- Action on TC by mode:
  - OFF: led held 0; ph unchanged.
  - ON: led held 1; ph unchanged.
  - BLINK: led <= ~led.
  - BURST: ph <= (ph==4B-1) ? 0 : ph+1. led <= 1 when new ph < 2B and new ph even, else 0. This gives B on/off blinks (each half H), then 2B·H cycles dark, repeating.
- Config write (cfg_we=1, cfg_ch<CHANNELS, reset=0): next cycle mode/H/B take the cfg values (0 substituted per rules). cnt becomes max(cfg_half,1)-1, ph becomes 0, evt becomes 0. led becomes OFF:0, ON:1, BLINK:0, BURST:1.
- cfg_ch ≥ CHANNELS: write ignored, no state change.
- Write and TC on the same channel in the same cycle: the write wins, with no toggle and no evt. Other channels are unaffected by a write.
- Arithmetic is unsigned. cnt never underflows because reload occurs at 0. 4B-1 max = 63, so ph is 6 bits.

## Timing
- Latency from write to output is one cycle: led and cnt reflect the new config on the edge after the cfg_we edge.
- BLINK, half H: first led rise on the H-th rising edge after reset deasserts (or after the write edge). The toggle period is H cycles and the full period is 2H. evt pulses every H cycles.
- BURST, H, B: led high for H cycles starting at the write edge+1. Pattern period is 4B·H cycles.
- ON and OFF: evt still pulses every H cycles, so it can be used as a tick.
- No handshake: writes are accepted every cycle, including back-to-back writes to the same channel (the last one wins).

## Test plan
- Reset then idle, DEFAULT_HALF overridden to 5 -> every channel led=0 for edges 1-4, led=1 on edge 5, toggles every 5 cycles; evt pulses on edges 5, 10, 15.
- Write ch1 BLINK H=3, then write ch2 BURST H=2 B=2 -> ch1 period 6. ch2 led sequence per 2 cycles is 1,0,1,0,0,0,0,0, repeating every 16 cycles. ch0 and ch3 are undisturbed.
- Write ch0 ON with H=0, and ch3 OFF -> ch0 led=1 constant with evt every cycle. ch3 led=0 constant.
- Write to ch0 timed exactly at its TC edge (H=4) -> no toggle and no evt that cycle. cnt=H-1 and led per new mode next cycle.
- Write with cfg_ch=CHANNELS (CHANNELS=3, CH_W=2, ch=3) -> no output changes for 20 cycles versus a golden model.
- Assert reset for 1 cycle mid-burst with cfg_we=1 the same cycle -> all outputs return to reset values, the write is discarded, and the first toggle occurs DEFAULT_HALF edges later.
